matmul_result_drain: RTL and testbench
======================================

// Module: matmul_result_drain
// PURPOSE
//   Consumer end of the matmul result interface. Captures the full parallel
//   LEFT_SIZE x RIGHT_SIZE result matrix on the matmul done pulse. Streams the
//   elements out one per beat, in row-major order, over a valid/ready interface.
//   Sits between matmul and the downstream writeback/DMA path.
// PARAMETERS
//   LEFT_SIZE   2   result rows (matches matmul left_size)
//   RIGHT_SIZE  4   result columns (matches matmul right_size)
//   DATA_W      32  element width
// PORTS
//   clk        in   1                       clock, all logic on posedge
//   rst_n      in   1                       reset, asynchronous, active-low
//   result_in  in   LEFT_SIZE*RIGHT_SIZE*DATA_W  packed matmul result
//   done_in    in   1                       one-cycle result-valid pulse from matmul
//   busy       out  1                       high while a captured matrix is draining
//   m_valid    out  1                       output beat valid
//   m_ready    in   1                       downstream accepts beat
//   m_data     out  DATA_W                  element value
//   m_row      out  $clog2(LEFT_SIZE)  (min 1)  row index of current beat
//   m_col      out  $clog2(RIGHT_SIZE) (min 1)  column index of current beat
//   m_last     out  1                       high on final element (row L-1, col R-1)
//   overrun    out  1                       sticky dropped-result flag (only with macro)
// BEHAVIOUR
//   - Packing: element (i,j) is result_in[(i*RIGHT_SIZE+j)*DATA_W +: DATA_W],
//     i.e. matmul's [L][R][DATA_W] packed layout.
//   - Reset (async, immediate): state=IDLE; capture register, row/col counters,
//     busy, m_valid, m_data, m_row, m_col, m_last and overrun all 0.
//   - FSM IDLE: m_valid=0, busy=0.
//     done_in=1 -> capture result_in, row=col=0, go to STREAM.
//   - FSM STREAM: busy=1, m_valid=1, m_data=captured[row][col].
//   - Latency: done_in sampled at edge N -> m_valid=1 with element (0,0) after edge N;
//     no combinational path from done_in to outputs.
//   - Handshake: a beat transfers on an edge where m_valid && m_ready.
//     With m_valid=1 and m_ready=0, m_data/m_row/m_col/m_last stay stable.
//     m_valid never drops before a transfer.
//   - Counter advance per transfer: col++. col==RIGHT_SIZE-1 -> col=0, row++.
//   - m_last = (row==LEFT_SIZE-1) && (col==RIGHT_SIZE-1), combinational from counters.
//   - Transfer with m_last=1 -> go to IDLE; m_valid=0 next cycle.
//   - Simultaneous done_in and last transfer: new matrix captured, row=col=0,
//     stay in STREAM. Back-to-back with no idle cycle.
//   - done_in in STREAM other than on the last transfer: pulse is dropped;
//     capture register is untouched and the current stream is unaffected.
//   - Exactly LEFT_SIZE*RIGHT_SIZE beats per captured matrix; no duplicates,
//     no skipped elements.
//   - Reset mid-stream: stream aborted, remaining beats discarded. After release
//     the block waits in IDLE for a fresh done_in.
// CONFIGURATION
//   MATMUL_DRAIN_OVERRUN_EN defined:
//     overrun port present; set to 1 the cycle after a dropped done_in pulse.
//     Stays 1 until rst_n.
//   MATMUL_DRAIN_OVERRUN_EN undefined:
//     overrun port and logic absent; dropped pulses are silent.
//   All other behaviour is identical in both builds.
// TESTING
//   1 Assert rst_n=0 mid-run -> all outputs 0 immediately; busy=0 after release.
//   2 Defaults, element(i,j)=i*4+j+1, pulse done_in, m_ready=1 -> 8 beats on
//     consecutive cycles, data 1..8, (row,col) (0,0)..(1,3), m_last only on
//     beat 8, busy=0 the cycle after.
//   3 Same matrix, m_ready alternating 1/0 -> outputs held while m_ready=0.
//     Data sequence still exactly 1..8 over 15 cycles.
//   4 done_in pulse at beat 3 with new data 100..107 -> stream still 1..8, then
//     IDLE; overrun=1 with macro, port absent without.
//   5 Second done_in (data 9..16) on the same edge as beat-8 transfer, m_ready=1
//     -> 16 contiguous beats 1..16, m_valid never low, m_last on beats 8 and 16.
//   6 rst_n low after beat 3 of matrix 1..8, then released -> m_valid=0;
//     no beats until the next done_in, whose stream starts at (0,0).

Source files
------------

// File: rtl/matmul_result_drain_if.sv
// rtl/matmul_result_drain_if.sv - result element stream interface for matmul_result_drain
//
// Purpose: bundles the valid/ready element stream that leaves the drain block.
// Ports (signals):
//   m_valid  master->slave  beat valid
//   m_ready  slave->master  downstream accepts beat
//   m_data   master->slave  element value (DATA_W)
//   m_row    master->slave  row index of current beat (ROW_W)
//   m_col    master->slave  column index of current beat (COL_W)
//   m_last   master->slave  final element of the matrix
interface matmul_result_drain_if #(
  parameter int DATA_W = 32,
  parameter int ROW_W  = 1,
  parameter int COL_W  = 2
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [ROW_W-1:0]  m_row;
  logic [COL_W-1:0]  m_col;
  logic              m_last;

  modport master (
    output m_valid, m_data, m_row, m_col, m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_data, m_row, m_col, m_last,
    output m_ready
  );
endinterface

// File: rtl/matmul_result_drain.sv
// rtl/matmul_result_drain.sv - captures a matmul result matrix and streams it out row-major
//
// Purpose: latches the packed LEFT_SIZE x RIGHT_SIZE result on the done_in pulse
// and drains one element per accepted beat over a valid/ready stream.
// Optional feature macro: MATMUL_DRAIN_OVERRUN_EN (adds sticky overrun output).
// Ports:
//   clk        in   clock, posedge
//   rst_n      in   asynchronous active-low reset
//   result_in  in   packed result, element (i,j) at [(i*RIGHT_SIZE+j)*DATA_W +: DATA_W]
//   done_in    in   one-cycle result-valid pulse
//   busy       out  high while a captured matrix is draining
//   overrun    out  sticky dropped-pulse flag (macro builds only)
//   m          master modport of matmul_result_drain_if (element stream)
module matmul_result_drain #(
  parameter int LEFT_SIZE  = 2,
  parameter int RIGHT_SIZE = 4,
  parameter int DATA_W     = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [LEFT_SIZE*RIGHT_SIZE*DATA_W-1:0] result_in,
  input  logic                                  done_in,
  output logic                                  busy,
`ifdef MATMUL_DRAIN_OVERRUN_EN
  output logic                                  overrun,
`endif
  matmul_result_drain_if.master                 m
);
  localparam int ROW_W = (LEFT_SIZE  > 1) ? $clog2(LEFT_SIZE)  : 1;
  localparam int COL_W = (RIGHT_SIZE > 1) ? $clog2(RIGHT_SIZE) : 1;
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(LEFT_SIZE - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(RIGHT_SIZE - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                                r_state;
  logic [LEFT_SIZE*RIGHT_SIZE*DATA_W-1:0] r_cap;
  logic [ROW_W-1:0]                      r_row;
  logic [COL_W-1:0]                      r_col;
  logic                                  r_valid;
  logic                                  r_busy;
`ifdef MATMUL_DRAIN_OVERRUN_EN
  logic                                  r_overrun;
`endif

  logic [DATA_W-1:0] w_elem [LEFT_SIZE][RIGHT_SIZE];
  logic              w_last;
  logic              w_xfer;
  logic              w_restart;

  for (genvar gi = 0; gi < LEFT_SIZE; gi++) begin : g_row
    for (genvar gj = 0; gj < RIGHT_SIZE; gj++) begin : g_col
      assign w_elem[gi][gj] = r_cap[(gi*RIGHT_SIZE+gj)*DATA_W +: DATA_W];
    end
  end

  assign w_last    = (r_row == ROW_MAX) && (r_col == COL_MAX);
  assign w_xfer    = r_valid && m.m_ready;
  // A done pulse coinciding with the final transfer starts the next matrix
  // without an idle cycle; any other done pulse while streaming is dropped.
  assign w_restart = w_xfer && w_last && done_in;

  // Data/index come straight from the capture register and counters, which
  // only move on a transfer, so they hold steady while m_ready is low.
  assign m.m_valid = r_valid;
  assign m.m_data  = w_elem[r_row][r_col];
  assign m.m_row   = r_row;
  assign m.m_col   = r_col;
  assign m.m_last  = w_last;
  assign busy      = r_busy;
`ifdef MATMUL_DRAIN_OVERRUN_EN
  assign overrun   = r_overrun;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cap     <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
`ifdef MATMUL_DRAIN_OVERRUN_EN
      r_overrun <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (done_in) begin
            r_cap   <= result_in;
            r_row   <= '0;
            r_col   <= '0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_xfer) begin
            if (w_last) begin
              r_row <= '0;
              r_col <= '0;
              if (done_in) begin
                r_cap <= result_in;
              end else begin
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end
            end else if (r_col == COL_MAX) begin
              r_col <= '0;
              r_row <= r_row + ROW_W'(1);
            end else begin
              r_col <= r_col + COL_W'(1);
            end
          end
`ifdef MATMUL_DRAIN_OVERRUN_EN
          if (done_in && !w_restart) begin
            r_overrun <= 1'b1;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matmul_result_drain.sv
// tb/tb_matmul_result_drain.sv - directed table-driven bench for matmul_result_drain
module tb_matmul_result_drain;
  localparam int L = 2;
  localparam int R = 4;
  localparam int W = 32;

  logic             clk;
  logic             rst_n;
  logic [L*R*W-1:0] result_in;
  logic             done_in;
  logic             busy;
`ifdef MATMUL_DRAIN_OVERRUN_EN
  logic             overrun;
`endif

  matmul_result_drain_if #(.DATA_W(W), .ROW_W(1), .COL_W(2)) s_if ();

  matmul_result_drain #(.LEFT_SIZE(L), .RIGHT_SIZE(R), .DATA_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .result_in (result_in),
    .done_in   (done_in),
    .busy      (busy),
`ifdef MATMUL_DRAIN_OVERRUN_EN
    .overrun   (overrun),
`endif
    .m         (s_if.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rdy;
    logic [31:0] data;
    logic [0:0]  row;
    logic [1:0]  col;
    logic        last;
  } vec_t;

  int checks;
  int failures;
  vec_t tab2 [8];
  vec_t tab3 [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [L*R*W-1:0] mk(input int base);
    logic [L*R*W-1:0] v;
    v = '0;
    for (int k = 0; k < L*R; k++) v[k*W +: W] = W'(base + k);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int base);
    result_in = mk(base);
    done_in   = 1'b1;
    step();
    done_in   = 1'b0;
  endtask

  task automatic chk_beat(input string tag, input int d, input int row, input int col, input logic last);
    chk({tag, " valid"}, 64'(s_if.m_valid), 64'd1);
    chk({tag, " busy"},  64'(busy), 64'd1);
    chk({tag, " data"},  64'(s_if.m_data), 64'(d));
    chk({tag, " row"},   64'(s_if.m_row), 64'(row));
    chk({tag, " col"},   64'(s_if.m_col), 64'(col));
    chk({tag, " last"},  64'(s_if.m_last), 64'(last));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " valid"}, 64'(s_if.m_valid), 64'd0);
    chk({tag, " busy"},  64'(busy), 64'd0);
  endtask

  task automatic apply_vec(input string tag, input vec_t v);
    s_if.m_ready = v.rdy;
    chk_beat(tag, int'(v.data), int'(v.row), int'(v.col), v.last);
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    tab2[0] = '{1'b1, 32'd1, 1'd0, 2'd0, 1'b0};
    tab2[1] = '{1'b1, 32'd2, 1'd0, 2'd1, 1'b0};
    tab2[2] = '{1'b1, 32'd3, 1'd0, 2'd2, 1'b0};
    tab2[3] = '{1'b1, 32'd4, 1'd0, 2'd3, 1'b0};
    tab2[4] = '{1'b1, 32'd5, 1'd1, 2'd0, 1'b0};
    tab2[5] = '{1'b1, 32'd6, 1'd1, 2'd1, 1'b0};
    tab2[6] = '{1'b1, 32'd7, 1'd1, 2'd2, 1'b0};
    tab2[7] = '{1'b1, 32'd8, 1'd1, 2'd3, 1'b1};

    tab3[0]  = '{1'b1, 32'd1, 1'd0, 2'd0, 1'b0};
    tab3[1]  = '{1'b0, 32'd2, 1'd0, 2'd1, 1'b0};
    tab3[2]  = '{1'b1, 32'd2, 1'd0, 2'd1, 1'b0};
    tab3[3]  = '{1'b0, 32'd3, 1'd0, 2'd2, 1'b0};
    tab3[4]  = '{1'b1, 32'd3, 1'd0, 2'd2, 1'b0};
    tab3[5]  = '{1'b0, 32'd4, 1'd0, 2'd3, 1'b0};
    tab3[6]  = '{1'b1, 32'd4, 1'd0, 2'd3, 1'b0};
    tab3[7]  = '{1'b0, 32'd5, 1'd1, 2'd0, 1'b0};
    tab3[8]  = '{1'b1, 32'd5, 1'd1, 2'd0, 1'b0};
    tab3[9]  = '{1'b0, 32'd6, 1'd1, 2'd1, 1'b0};
    tab3[10] = '{1'b1, 32'd6, 1'd1, 2'd1, 1'b0};
    tab3[11] = '{1'b0, 32'd7, 1'd1, 2'd2, 1'b0};
    tab3[12] = '{1'b1, 32'd7, 1'd1, 2'd2, 1'b0};
    tab3[13] = '{1'b0, 32'd8, 1'd1, 2'd3, 1'b1};
    tab3[14] = '{1'b1, 32'd8, 1'd1, 2'd3, 1'b1};

    rst_n        = 1'b0;
    done_in      = 1'b0;
    result_in    = '0;
    s_if.m_ready = 1'b0;
    #1;
    chk("reset valid", 64'(s_if.m_valid), 64'd0);
    chk("reset busy",  64'(busy), 64'd0);
    chk("reset data",  64'(s_if.m_data), 64'd0);
    chk("reset row",   64'(s_if.m_row), 64'd0);
    chk("reset col",   64'(s_if.m_col), 64'd0);
    chk("reset last",  64'(s_if.m_last), 64'd0);
`ifdef MATMUL_DRAIN_OVERRUN_EN
    chk("reset overrun", 64'(overrun), 64'd0);
`endif
    #11;
    rst_n = 1'b1;
    step();
    step();
    chk_idle("idle before pulse");

    // Full-rate drain of 1..8.
    s_if.m_ready = 1'b1;
    pulse(1);
    for (int i = 0; i < 8; i++) apply_vec($sformatf("t2 beat%0d", i), tab2[i]);
    chk_idle("t2 after");

    // Alternating ready: 15 cycles for 8 transfers, outputs held while stalled.
    pulse(1);
    for (int i = 0; i < 15; i++) apply_vec($sformatf("t3 cyc%0d", i), tab3[i]);
    chk_idle("t3 after");
`ifdef MATMUL_DRAIN_OVERRUN_EN
    chk("t3 overrun clear", 64'(overrun), 64'd0);
`endif

    // Dropped done pulse at beat 3 must not disturb the stream.
    s_if.m_ready = 1'b1;
    pulse(1);
    for (int k = 0; k < 8; k++) begin
      chk_beat($sformatf("t4 beat%0d", k), k + 1, k / 4, k % 4, k == 7);
      if (k == 2) begin
        result_in = mk(100);
        done_in   = 1'b1;
      end
      step();
      done_in = 1'b0;
    end
    chk_idle("t4 after");
`ifdef MATMUL_DRAIN_OVERRUN_EN
    chk("t4 overrun set", 64'(overrun), 64'd1);
`endif
    step();
    chk_idle("t4 stays idle");

    // Back-to-back: second done on the last transfer edge.
    pulse(1);
    for (int k = 0; k < 16; k++) begin
      chk_beat($sformatf("t5 beat%0d", k), k + 1, (k % 8) / 4, k % 4, (k == 7) || (k == 15));
      if (k == 7) begin
        result_in = mk(9);
        done_in   = 1'b1;
      end
      step();
      done_in = 1'b0;
    end
    chk_idle("t5 after");

    // Reset mid-stream after three beats.
    pulse(1);
    for (int k = 0; k < 3; k++) begin
      chk_beat($sformatf("t6 beat%0d", k), k + 1, 0, k, 1'b0);
      step();
    end
    chk_beat("t6 pre-reset", 4, 0, 3, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6 rst valid", 64'(s_if.m_valid), 64'd0);
    chk("t6 rst busy",  64'(busy), 64'd0);
    chk("t6 rst data",  64'(s_if.m_data), 64'd0);
    chk("t6 rst row",   64'(s_if.m_row), 64'd0);
    chk("t6 rst col",   64'(s_if.m_col), 64'd0);
    chk("t6 rst last",  64'(s_if.m_last), 64'd0);
`ifdef MATMUL_DRAIN_OVERRUN_EN
    chk("t6 rst overrun", 64'(overrun), 64'd0);
`endif
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk_idle($sformatf("t6 idle%0d", c));
    end
    pulse(20);
    chk_beat("t6 restart", 20, 0, 0, 1'b0);
    step();
    chk_beat("t6 restart2", 21, 0, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
